// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default bit period and frame-length helper.
// Used by uart_tx (optional UART_TX_PARITY_EN) and uart_baud_gen.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   // 50 MHz system clock at 115200 baud
   localparam int unsigned CLKS_PER_BIT_DEF = 434;

   function automatic int unsigned frame_clks(
      input int unsigned clks,
      input int unsigned stop_bits,
      input bit          parity
   );
      return (9 + (parity ? 1 : 0) + stop_bits) * clks;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with synchronous clear.
// bit_end is high for the last cycle of each bit period.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic bit_end
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
      end
   end

   assign bit_end = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serial transmitter behind a level start / ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o,
   output logic       tx_o,
   output logic       tx_done_o
);

   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   uart_state_t state;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        armed;
   logic        accept;
   logic        busy;
   logic        bit_end;
`ifdef UART_TX_PARITY_EN
   logic        par_q;
`endif

   assign accept = (state == IDLE) && tx_start_i && armed;
   assign busy   = (state != IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (accept),
      .en     (busy),
      .bit_end(bit_end)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         armed      <= 1'b1;
         tx_o       <= 1'b1;
         tx_ready_o <= 1'b1;
         tx_done_o  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         tx_done_o <= 1'b0;

         // a start held across frame end must drop before re-arming
         if (accept)
            armed <= 1'b0;
         else if (!tx_start_i)
            armed <= 1'b1;

         unique case (state)
            IDLE: begin
               if (accept) begin
                  shreg      <= tx_data_i;
                  bit_cnt    <= '0;
                  tx_o       <= 1'b0;
                  tx_ready_o <= 1'b0;
                  state      <= START;
`ifdef UART_TX_PARITY_EN
                  par_q      <= ^tx_data_i;
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  tx_o    <= shreg[0];
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_o    <= par_q;
                     state   <= PARITY;
`else
                     tx_o    <= 1'b1;
                     state   <= STOP;
`endif
                  end else begin
                     shreg   <= {1'b0, shreg[7:1]};
                     tx_o    <= shreg[1];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  tx_o    <= 1'b1;
                  bit_cnt <= '0;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt    <= '0;
                     tx_ready_o <= 1'b1;
                     tx_done_o  <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: begin
               tx_o       <= 1'b1;
               tx_ready_o <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
